apb_mst_ctrl: RTL and testbench
===============================

Name: apb_mst_ctrl

Overview:
- APB initiator that converts a single-outstanding command/response interface into APB3/APB4 transfers on the `tim_*` bus.
- Drives the timer's APB slave port from on-chip logic (CPU bridge or sequencer) in place of a testbench master.
- Handles SETUP/ACCESS sequencing, wait states, PSLVERR capture and a PREADY timeout.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width; PSTRB width is DATA_W/8.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- sys_clk  in  1  single clock; all logic is on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  byte strobes; ignored on reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- tim_psel, tim_penable, tim_pwrite  out  1 each  APB control.
- tim_paddr  out  ADDR_W  APB address.
- tim_pwdata  out  DATA_W  APB write data.
- tim_pstrb  out  DATA_W/8  APB strobes.
- tim_prdata  in  DATA_W  APB read data.
- tim_pready  in  1  APB ready.
- tim_pslverr  in  1  APB error.

Behaviour:
- Reset values (sys_rst high at an edge):
  - state = IDLE.
  - psel, penable, pwrite, pstrb, paddr, pwdata = 0.
  - rsp_valid, rsp_err, rsp_timeout, rsp_rdata = 0.
  - Wait counter = 0.
  - Reset mid-transfer drops psel/penable at that same edge; the in-flight response is discarded.
- States are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1 (combinational from state); it is 0 in every other state.
  - On cmd_valid & cmd_ready, register the command and go to SETUP.
- SETUP (one cycle):
  - psel = 1, penable = 0.
  - paddr, pwrite and pwdata are driven from the registered command.
  - pstrb = cmd_strb on writes, 4'b0000 on reads.
  - Unconditionally go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1; address, data, write and strobes are held stable.
  - If tim_pready = 1:
    - Capture rsp_rdata = tim_prdata (reads only; writes return 0).
    - Capture rsp_err = tim_pslverr.
    - Go to RESP.
  - Else, increment the wait counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT:
    - Go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - tim_pslverr and tim_prdata are ignored while tim_pready = 0.
- Bus release (on leaving ACCESS):
  - psel, penable, pwrite and pstrb return to 0.
  - paddr and pwdata hold their last value.
- RESP:
  - rsp_valid = 1, with rsp_* stable until rsp_ready.
  - On rsp_ready, go to IDLE and clear the wait counter.
  - rsp_ready while not in RESP has no effect.
- Latency, zero-wait slave:
  - Accept at edge N.
  - SETUP during N+1, ACCESS during N+2, rsp_valid during N+3.
  - With rsp_ready held high, the next accept is possible at N+4, giving a 4-cycle throughput.
  - Each wait state adds one cycle.
- Only one transfer is outstanding; there is no pipelining of SETUP under RESP.
- Simultaneous tim_pready = 1 on the cycle the counter would reach TIMEOUT: pready wins, the transfer completes normally with rsp_timeout = 0.
- Commands presented while cmd_ready = 0 are held by the requester and are not lost or sampled.

Test Plan:
- Write, zero-wait slave: cmd write, addr 0x000, wdata 0x0000_0003, strb 1111.
  - Expect psel 1 cycle after accept, penable 1 cycle later.
  - Expect pstrb = 1111 and pwdata = 0x3 stable.
  - Expect rsp_valid 3 cycles after accept, rsp_err = 0, rsp_rdata = 0.
- Read with 2 wait states: addr 0x004, slave returns 0x1234_5678 after 2 low-pready cycles.
  - Expect pstrb = 0000 and penable high for 3 cycles.
  - Expect rsp_rdata = 0x1234_5678, rsp_valid 5 cycles after accept.
- Slave error: write addr 0xFFC, slave responds pready = 1, pslverr = 1.
  - Expect rsp_err = 1, rsp_timeout = 0.
  - Expect pslverr = 1 driven during a wait cycle before that to be ignored.
- Timeout: TIMEOUT = 16, pready held 0.
  - Expect the bus released after 16 ACCESS cycles.
  - Expect rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Expect the next command to be accepted normally.
- Backpressure and reset:
  - Hold rsp_ready = 0 for 5 cycles: rsp_* stable, cmd_ready = 0 throughout.
  - Assert sys_rst during ACCESS: all outputs 0 at that same edge, state IDLE, no rsp_valid afterwards.

Source files
------------

// File: rtl/apb_mst_ctrl_if.sv
// Command/response and APB bus bundle for apb_mst_ctrl.
// The master modport is the controller's view; slave is the requester + APB target side.
interface apb_mst_ctrl_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_strb;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic              tim_psel;
   logic              tim_penable;
   logic              tim_pwrite;
   logic [ADDR_W-1:0] tim_paddr;
   logic [DATA_W-1:0] tim_pwdata;
   logic [STRB_W-1:0] tim_pstrb;
   logic [DATA_W-1:0] tim_prdata;
   logic              tim_pready;
   logic              tim_pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             tim_prdata, tim_pready, tim_pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             tim_prdata, tim_pready, tim_pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
   );
endinterface

// File: rtl/apb_mst_ctrl.sv
// APB3/APB4 initiator: one outstanding command turned into a SETUP/ACCESS transfer,
// with wait states, PSLVERR capture and an optional PREADY timeout.
module apb_mst_ctrl #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   apb_mst_ctrl_if.master bus
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] strb_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              timeout_q;

   logic              accept;
   logic              timeout_hit;
   logic [31:0]       cnt_inc;
   logic              bus_active;

   always_comb begin
      cnt_inc     = 32'(wait_cnt_q) + 32'd1;
      accept      = (state_q == StIdle) && bus.cmd_valid;
      // Only meaningful while PREADY is low; a simultaneous PREADY takes priority.
      timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         strb_q     <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (accept) begin
            write_q <= bus.cmd_write;
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            strb_q  <= bus.cmd_strb;
         end
         if (state_q == StAccess) begin
            if (bus.tim_pready) begin
               rdata_q   <= write_q ? '0 : bus.tim_prdata;
               err_q     <= bus.tim_pslverr;
               timeout_q <= 1'b0;
            end else if (timeout_hit) begin
               rdata_q   <= '0;
               err_q     <= 1'b1;
               timeout_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         StIdle:   if (bus.cmd_valid) state_d = StSetup;
         StSetup:  state_d = StAccess;
         StAccess: begin
            if (bus.tim_pready) begin
               state_d = StResp;
            end else begin
               wait_cnt_d = CNT_W'(cnt_inc);
               if (timeout_hit) state_d = StResp;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d    = StIdle;
               wait_cnt_d = '0;
            end
         end
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      bus_active      = (state_q == StSetup) || (state_q == StAccess);
      bus.cmd_ready   = (state_q == StIdle);
      bus.tim_psel    = bus_active;
      bus.tim_penable = (state_q == StAccess);
      bus.tim_pwrite  = bus_active && write_q;
      bus.tim_pstrb   = (bus_active && write_q) ? strb_q : '0;
      // Address and data keep their last value after release.
      bus.tim_paddr   = addr_q;
      bus.tim_pwdata  = wdata_q;
      bus.rsp_valid   = (state_q == StResp);
      bus.rsp_rdata   = rdata_q;
      bus.rsp_err     = err_q;
      bus.rsp_timeout = timeout_q;
   end
endmodule

// File: tb/tb_apb_mst_ctrl.sv
// Self-checking bench for apb_mst_ctrl: directed scenarios plus randomized transfers
// compared against a transfer-level reference model.
module tb_apb_mst_ctrl;
   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned STRB_W  = DATA_W / 8;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;

   apb_mst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_mst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   // Observations of the most recent transfer
   int                obs_accept_cyc, obs_setup_k, obs_pen_cnt, obs_rsp_k;
   int                obs_bus_unstable, obs_rsp_unstable, obs_cmd_ready_busy;
   logic [ADDR_W-1:0] obs_paddr;
   logic [DATA_W-1:0] obs_pwdata;
   logic [STRB_W-1:0] obs_pstrb;
   logic              obs_pwrite;
   logic [DATA_W-1:0] obs_rdata;
   logic              obs_err, obs_to;
   bit                obs_done;
   bit                slv_wait_err = 1'b0;

   // Expected results from the reference model
   int                exp_rsp_k, exp_pen_cnt;
   logic [DATA_W-1:0] exp_rdata;
   logic              exp_err, exp_to;

   // Slave holds PREADY low for `waits` ACCESS cycles, then completes.
   task automatic model(input bit wr, input int waits, input logic [DATA_W-1:0] rdata,
                        input bit err);
      bit to;
      to          = (TIMEOUT != 0) && (waits >= int'(TIMEOUT));
      exp_pen_cnt = to ? int'(TIMEOUT) : waits + 1;
      exp_rsp_k   = exp_pen_cnt + 2;
      exp_rdata   = (wr || to) ? '0 : rdata;
      exp_err     = to ? 1'b1 : err;
      exp_to      = to;
   endtask

   task automatic run_xfer(input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                           input int waits, input logic [DATA_W-1:0] rdata, input bit err,
                           input int hold);
      int acc;
      int held;
      bit seen_psel;
      bit got;
      obs_accept_cyc = -1; obs_setup_k = -1; obs_pen_cnt = 0; obs_rsp_k = -1;
      obs_bus_unstable = 0; obs_rsp_unstable = 0; obs_cmd_ready_busy = 0; obs_done = 0;
      @(negedge sys_clk);
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_strb  = strb;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         if (bus.cmd_ready) got = 1;
         else @(negedge sys_clk);
      end
      if (!got) begin
         n_checks++;
         $display("FAIL accept: cmd_ready=0 after 50 cycles, required 1");
         bus.cmd_valid = 1'b0;
         return;
      end
      @(negedge sys_clk);
      obs_accept_cyc = cyc;
      // Scramble the command lines; the DUT must use its registered copy.
      bus.cmd_valid  = 1'b0;
      bus.cmd_write  = 1'($urandom);
      bus.cmd_addr   = ADDR_W'($urandom);
      bus.cmd_wdata  = $urandom;
      bus.cmd_strb   = STRB_W'($urandom);
      acc = 0; held = 0; seen_psel = 0;
      for (int k = 1; k <= 200; k++) begin
         if (k > 1) @(negedge sys_clk);
         if (bus.cmd_ready) obs_cmd_ready_busy++;
         if (bus.tim_psel) begin
            if (!seen_psel) begin
               seen_psel   = 1;
               obs_setup_k = bus.tim_penable ? -2 : k;
               obs_paddr   = bus.tim_paddr;
               obs_pwdata  = bus.tim_pwdata;
               obs_pstrb   = bus.tim_pstrb;
               obs_pwrite  = bus.tim_pwrite;
            end else if (bus.tim_paddr !== obs_paddr || bus.tim_pwdata !== obs_pwdata ||
                         bus.tim_pstrb !== obs_pstrb || bus.tim_pwrite !== obs_pwrite) begin
               obs_bus_unstable++;
            end
         end
         if (bus.tim_psel && bus.tim_penable) begin
            obs_pen_cnt++;
            if (acc < waits) begin
               bus.tim_pready  = 1'b0;
               bus.tim_pslverr = slv_wait_err ? 1'b1 : 1'($urandom);
               bus.tim_prdata  = $urandom;
            end else begin
               bus.tim_pready  = 1'b1;
               bus.tim_pslverr = err;
               bus.tim_prdata  = rdata;
            end
            acc++;
         end else begin
            bus.tim_pready  = 1'($urandom);
            bus.tim_pslverr = 1'($urandom);
            bus.tim_prdata  = $urandom;
         end
         if (bus.rsp_valid) begin
            if (obs_rsp_k < 0) begin
               obs_rsp_k = k;
               obs_rdata = bus.rsp_rdata;
               obs_err   = bus.rsp_err;
               obs_to    = bus.rsp_timeout;
            end else if (bus.rsp_rdata !== obs_rdata || bus.rsp_err !== obs_err ||
                         bus.rsp_timeout !== obs_to) begin
               obs_rsp_unstable++;
            end
            if (held >= hold) begin
               bus.rsp_ready = 1'b1;
               @(posedge sys_clk);
               obs_done = 1;
               break;
            end
            bus.rsp_ready = 1'b0;
            held++;
         end else begin
            bus.rsp_ready = 1'($urandom);
         end
      end
      if (!obs_done) begin
         n_checks++;
         $display("FAIL rsp_wait: rsp_valid handshake missing after 200 cycles");
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      n_checks++;
      if ({bus.tim_psel, bus.tim_penable, bus.tim_pwrite, bus.tim_pstrb} !== '0)
         $display("FAIL reset_ctrl: psel/penable/pwrite/pstrb=%b required 0",
                  {bus.tim_psel, bus.tim_penable, bus.tim_pwrite, bus.tim_pstrb});
      else n_pass++;
      n_checks++;
      if ({bus.tim_paddr, bus.tim_pwdata} !== '0)
         $display("FAIL reset_addr: paddr=%h pwdata=%h required 0", bus.tim_paddr, bus.tim_pwdata);
      else n_pass++;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== '0)
         $display("FAIL reset_rsp: valid=%b err=%b to=%b rdata=%h required 0", bus.rsp_valid,
                  bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
      else n_pass++;
      n_checks++;
      if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: cmd_ready=%b required 1", bus.cmd_ready);
      else n_pass++;
      sys_rst = 1'b0;
   endtask

   task automatic test_write_zero_wait();
      run_xfer(1'b1, 12'h000, 32'h0000_0003, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0);
      model(1'b1, 0, 32'hDEAD_BEEF, 1'b0);
      n_checks++;
      if (obs_setup_k !== 1) $display("FAIL wr_setup_k: got %0d required 1", obs_setup_k);
      else n_pass++;
      n_checks++;
      if (obs_pen_cnt !== exp_pen_cnt) $display("FAIL wr_pen_cnt: got %0d required %0d", obs_pen_cnt, exp_pen_cnt);
      else n_pass++;
      n_checks++;
      if (obs_pstrb !== 4'hF || obs_pwdata !== 32'h3 || obs_pwrite !== 1'b1 || obs_paddr !== 12'h000)
         $display("FAIL wr_bus: pstrb=%h pwdata=%h pwrite=%b paddr=%h required f/3/1/000",
                  obs_pstrb, obs_pwdata, obs_pwrite, obs_paddr);
      else n_pass++;
      n_checks++;
      if (obs_bus_unstable !== 0) $display("FAIL wr_stable: %0d changes required 0", obs_bus_unstable);
      else n_pass++;
      n_checks++;
      if (obs_rsp_k !== exp_rsp_k) $display("FAIL wr_rsp_lat: got %0d required %0d", obs_rsp_k, exp_rsp_k);
      else n_pass++;
      n_checks++;
      if (obs_err !== exp_err || obs_rdata !== exp_rdata || obs_to !== exp_to)
         $display("FAIL wr_rsp: err=%b rdata=%h to=%b required %b/%h/%b", obs_err, obs_rdata,
                  obs_to, exp_err, exp_rdata, exp_to);
      else n_pass++;
   endtask

   task automatic test_read_wait();
      run_xfer(1'b0, 12'h004, $urandom, 4'hF, 2, 32'h1234_5678, 1'b0, 0);
      model(1'b0, 2, 32'h1234_5678, 1'b0);
      n_checks++;
      if (obs_pstrb !== 4'h0 || obs_pwrite !== 1'b0 || obs_paddr !== 12'h004)
         $display("FAIL rd_bus: pstrb=%h pwrite=%b paddr=%h required 0/0/004", obs_pstrb,
                  obs_pwrite, obs_paddr);
      else n_pass++;
      n_checks++;
      if (obs_pen_cnt !== exp_pen_cnt) $display("FAIL rd_pen_cnt: got %0d required %0d", obs_pen_cnt, exp_pen_cnt);
      else n_pass++;
      n_checks++;
      if (obs_rsp_k !== exp_rsp_k) $display("FAIL rd_rsp_lat: got %0d required %0d", obs_rsp_k, exp_rsp_k);
      else n_pass++;
      n_checks++;
      if (obs_rdata !== exp_rdata || obs_err !== exp_err)
         $display("FAIL rd_rsp: rdata=%h err=%b required %h/%b", obs_rdata, obs_err, exp_rdata, exp_err);
      else n_pass++;
   endtask

   task automatic test_slave_error();
      slv_wait_err = 1'b1;
      run_xfer(1'b1, 12'hFFC, $urandom, 4'hF, 1, '0, 1'b1, 0);
      n_checks++;
      if (obs_err !== 1'b1 || obs_to !== 1'b0)
         $display("FAIL slverr: err=%b to=%b required 1/0", obs_err, obs_to);
      else n_pass++;
      run_xfer(1'b0, 12'h010, $urandom, 4'h0, 2, 32'hA5A5_0F0F, 1'b0, 0);
      n_checks++;
      if (obs_err !== 1'b0 || obs_rdata !== 32'hA5A5_0F0F)
         $display("FAIL slverr_ignored: err=%b rdata=%h required 0/a5a50f0f", obs_err, obs_rdata);
      else n_pass++;
      slv_wait_err = 1'b0;
   endtask

   task automatic test_timeout();
      run_xfer(1'b0, 12'h020, $urandom, 4'hF, int'(TIMEOUT) + 5, 32'h5555_AAAA, 1'b0, 0);
      n_checks++;
      if (obs_pen_cnt !== int'(TIMEOUT)) $display("FAIL to_pen_cnt: got %0d required %0d", obs_pen_cnt, TIMEOUT);
      else n_pass++;
      n_checks++;
      if (obs_rsp_k !== int'(TIMEOUT) + 2) $display("FAIL to_rsp_lat: got %0d required %0d", obs_rsp_k, TIMEOUT + 2);
      else n_pass++;
      n_checks++;
      if (obs_err !== 1'b1 || obs_to !== 1'b1 || obs_rdata !== '0)
         $display("FAIL to_rsp: err=%b to=%b rdata=%h required 1/1/0", obs_err, obs_to, obs_rdata);
      else n_pass++;
      // PREADY on the very cycle the counter would expire wins
      run_xfer(1'b0, 12'h024, $urandom, 4'hF, int'(TIMEOUT) - 1, 32'h0BAD_F00D, 1'b0, 0);
      n_checks++;
      if (obs_to !== 1'b0 || obs_err !== 1'b0 || obs_rdata !== 32'h0BAD_F00D)
         $display("FAIL to_boundary: to=%b err=%b rdata=%h required 0/0/0badf00d", obs_to, obs_err, obs_rdata);
      else n_pass++;
      run_xfer(1'b0, 12'h028, $urandom, 4'hF, 0, 32'h1357_9BDF, 1'b0, 0);
      n_checks++;
      if (obs_rsp_k !== 3 || obs_rdata !== 32'h1357_9BDF || obs_to !== 1'b0)
         $display("FAIL to_recover: rsp_k=%0d rdata=%h to=%b required 3/13579bdf/0", obs_rsp_k, obs_rdata, obs_to);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int first;
      run_xfer(1'b1, 12'h030, $urandom, 4'h3, 0, '0, 1'b0, 0);
      first = obs_accept_cyc;
      run_xfer(1'b1, 12'h034, $urandom, 4'hC, 0, '0, 1'b0, 0);
      n_checks++;
      if (obs_accept_cyc - first !== 4)
         $display("FAIL throughput: accept spacing %0d required 4", obs_accept_cyc - first);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      run_xfer(1'b0, 12'h040, $urandom, 4'hF, 1, 32'hCAFE_0001, 1'b0, 5);
      n_checks++;
      if (obs_rsp_unstable !== 0) $display("FAIL bp_stable: %0d changes required 0", obs_rsp_unstable);
      else n_pass++;
      n_checks++;
      if (obs_cmd_ready_busy !== 0) $display("FAIL bp_ready: cmd_ready high %0d cycles required 0", obs_cmd_ready_busy);
      else n_pass++;
      n_checks++;
      if (obs_rdata !== 32'hCAFE_0001) $display("FAIL bp_rdata: got %h required cafe0001", obs_rdata);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int busy;
      bit got;
      @(negedge sys_clk);
      bus.rsp_ready = 1'b0;
      bus.tim_pready = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 12'h0AB;
      bus.cmd_wdata = 32'h7777_7777; bus.cmd_strb = 4'hF;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge sys_clk);
         bus.cmd_valid = 1'b0;
         if (bus.tim_penable) got = 1;
      end
      n_checks++;
      if (!got) $display("FAIL rst_mid_access: penable=0 after 20 cycles required 1");
      else n_pass++;
      sys_rst = 1'b1;
      bus.tim_pready = 1'b1;
      @(posedge sys_clk);
      #1;
      n_checks++;
      if ({bus.tim_psel, bus.tim_penable, bus.tim_pwrite, bus.tim_pstrb, bus.tim_paddr,
           bus.tim_pwdata} !== '0)
         $display("FAIL rst_mid_bus: psel=%b pen=%b pwrite=%b pstrb=%h paddr=%h pwdata=%h required 0",
                  bus.tim_psel, bus.tim_penable, bus.tim_pwrite, bus.tim_pstrb, bus.tim_paddr,
                  bus.tim_pwdata);
      else n_pass++;
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
         $display("FAIL rst_mid_state: cmd_ready=%b rsp_valid=%b required 1/0", bus.cmd_ready, bus.rsp_valid);
      else n_pass++;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      busy = 0;
      repeat (6) begin
         @(negedge sys_clk);
         if (bus.rsp_valid || bus.tim_psel) busy++;
      end
      n_checks++;
      if (busy !== 0) $display("FAIL rst_mid_after: rsp_valid/psel high %0d cycles required 0", busy);
      else n_pass++;
   endtask

   task automatic test_random();
      bit                wr, err;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata, rdata;
      logic [STRB_W-1:0] strb;
      int                waits, hold, r;
      for (int n = 0; n < 24; n++) begin
         wr = 1'($urandom); err = 1'($urandom);
         addr = ADDR_W'($urandom); wdata = $urandom; rdata = $urandom;
         strb = STRB_W'($urandom);
         r = int'($urandom_range(0, 7));
         if (r < 5) waits = r % 4;
         else if (r == 5) waits = int'(TIMEOUT) - 1;
         else if (r == 6) waits = int'(TIMEOUT);
         else waits = int'(TIMEOUT) + int'($urandom_range(1, 3));
         hold = int'($urandom_range(0, 3));
         run_xfer(wr, addr, wdata, strb, waits, rdata, err, hold);
         model(wr, waits, rdata, err);
         n_checks++;
         if (obs_rsp_k !== exp_rsp_k || obs_pen_cnt !== exp_pen_cnt)
            $display("FAIL rnd%0d_timing: rsp_k=%0d pen=%0d required %0d/%0d", n, obs_rsp_k,
                     obs_pen_cnt, exp_rsp_k, exp_pen_cnt);
         else n_pass++;
         n_checks++;
         if (obs_rdata !== exp_rdata || obs_err !== exp_err || obs_to !== exp_to)
            $display("FAIL rnd%0d_rsp: rdata=%h err=%b to=%b required %h/%b/%b", n, obs_rdata,
                     obs_err, obs_to, exp_rdata, exp_err, exp_to);
         else n_pass++;
         n_checks++;
         if (obs_paddr !== addr || obs_pwdata !== wdata || obs_pwrite !== wr ||
             obs_pstrb !== (wr ? strb : '0) || obs_setup_k !== 1)
            $display("FAIL rnd%0d_bus: paddr=%h pwdata=%h pwrite=%b pstrb=%h setup_k=%0d required %h/%h/%b/%h/1",
                     n, obs_paddr, obs_pwdata, obs_pwrite, obs_pstrb, obs_setup_k, addr, wdata, wr,
                     wr ? strb : 4'h0);
         else n_pass++;
         n_checks++;
         if (obs_bus_unstable !== 0 || obs_rsp_unstable !== 0 || obs_cmd_ready_busy !== 0)
            $display("FAIL rnd%0d_stable: bus=%0d rsp=%0d ready=%0d required 0/0/0", n,
                     obs_bus_unstable, obs_rsp_unstable, obs_cmd_ready_busy);
         else n_pass++;
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
      bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.rsp_ready = 1'b0;
      bus.tim_prdata = '0; bus.tim_pready = 1'b0; bus.tim_pslverr = 1'b0;
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_slave_error();
      test_timeout();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish by 300000, required earlier");
      $fatal(1);
   end
endmodule
